mem_arbiter: RTL and testbench

- Shares one unified 32-bit memory bus between the core's instruction-fetch port and its load/store port.
- Sequences single-outstanding bus transactions with a req/ack handshake and a one-entry fetch buffer.
- Generates the 6-bit pipeline stall vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved.
- Sits between the mips core and the external memory, replacing the separate rom/ram ports.

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/mem_arbiter_if.sv | 10 +
 rtl/mem_arb_fetch_buf.sv | 31 +++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, stall vectors and FSM states for the memory arbiter
package mem_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int INST_ADDR_W = 32;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_FETCH = 6'b000011;
  localparam logic [5:0] STALL_DATA = 6'b011111;
  typedef enum logic [1:0] {IDLE, DATA_REQ, INST_REQ} arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-outstanding req/ack memory bus with sticky timeout flag
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  import mem_arbiter_pkg::*;
  logic req, we, ack, err;
  logic [3:0] sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master (output req, we, sel, addr, wdata, err, input rdata, ack);
  modport slave (input req, we, sel, addr, wdata, err, output rdata, ack);
endinterface

// File: rtl/mem_arb_fetch_buf.sv
// mem_arb_fetch_buf: one-entry tagged instruction buffer, invalidated when consumed
module mem_arb_fetch_buf
  import mem_arbiter_pkg::*;
#(parameter int ADDR_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_consume,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);
  logic r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;
  assign o_hit = r_valid && r_tag == i_addr;
  assign o_data = r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag <= '0;
      r_data <= '0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_tag <= i_waddr;
      r_data <= i_wdata;
    end else if (i_consume) r_valid <= 1'b0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and load/store, generating pipeline stalls
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic [5:0]        stall_o,
  mem_arbiter_if.master     bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  arb_state_e r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rdata, w_rdata, w_buf_data;
  logic w_busy, w_expire, w_done, w_data_done, w_inst_done, w_hit, w_consume;
  assign w_busy = r_state != IDLE;
  assign w_expire = w_busy && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign w_done = w_busy && (bus.ack || w_expire);
  assign w_rdata = bus.ack ? bus.rdata : '0;
  assign w_data_done = w_done && r_state == DATA_REQ;
  assign w_inst_done = w_done && r_state == INST_REQ;
  assign stall_o = rst ? STALL_NONE :
                   data_ce_i && !w_data_done ? STALL_DATA :
                   inst_ce_i && !w_hit ? STALL_FETCH : STALL_NONE;
  assign w_consume = inst_ce_i && w_hit && !stall_o[1];
  assign inst_data_o = inst_ce_i && w_hit ? w_buf_data : '0;
  assign data_rdata_o = w_data_done ? w_rdata : r_rdata;
  mem_arb_fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
    .clk(clk),
    .rst(rst),
    .i_wr(w_inst_done),
    .i_waddr(bus.addr),
    .i_wdata(w_rdata),
    .i_addr(inst_addr_i),
    .i_consume(w_consume),
    .o_hit(w_hit),
    .o_data(w_buf_data)
  );
  // Issuing only from IDLE guarantees one idle bus cycle between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rdata <= '0;
      bus.req <= 1'b0;
      bus.we <= 1'b0;
      bus.sel <= '0;
      bus.addr <= '0;
      bus.wdata <= '0;
      bus.err <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (data_ce_i) begin
        r_state <= DATA_REQ;
        bus.req <= 1'b1;
        bus.we <= data_we_i;
        bus.sel <= data_sel_i;
        bus.addr <= data_addr_i;
        bus.wdata <= data_wdata_i;
      end else if (inst_ce_i && !w_hit) begin
        r_state <= INST_REQ;
        bus.req <= 1'b1;
        bus.we <= 1'b0;
        bus.sel <= 4'hF;
        bus.addr <= inst_addr_i;
        bus.wdata <= '0;
      end
    end else if (w_done) begin
      r_state <= IDLE;
      bus.req <= 1'b0;
      if (!bus.ack) bus.err <= 1'b1;
      if (w_data_done) r_rdata <= w_rdata;
    end else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, store, collision, timeout and mid-transaction reset
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic inst_ce_i, data_ce_i, data_we_i;
  logic [3:0] data_sel_i;
  logic [31:0] inst_addr_i, data_addr_i, data_wdata_i, inst_data_o, data_rdata_o;
  logic [5:0] stall_o;
  int n_cmp = 0;
  int n_bad = 0;
  mem_arbiter_if bus_if ();
  mem_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .inst_ce_i(inst_ce_i),
    .inst_addr_i(inst_addr_i),
    .inst_data_o(inst_data_o),
    .data_ce_i(data_ce_i),
    .data_we_i(data_we_i),
    .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o),
    .stall_o(stall_o),
    .bus(bus_if)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic data_req(input logic we, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd);
    data_ce_i = 1'b1;
    data_we_i = we;
    data_sel_i = sel;
    data_addr_i = addr;
    data_wdata_i = wd;
  endtask
  initial begin
    rst = 1'b1;
    inst_ce_i = 1'b0;
    inst_addr_i = '0;
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
    data_sel_i = '0;
    data_addr_i = '0;
    data_wdata_i = '0;
    bus_if.ack = 1'b0;
    bus_if.rdata = '0;
    step();
    step();
    chk("rst_stall", 32'(stall_o), 32'(STALL_NONE));
    chk("rst_req", 32'(bus_if.req), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    chk("rst_inst_data", inst_data_o, 32'h0);
    chk("rst_data_rdata", data_rdata_o, 32'h0);
    rst = 1'b0;
    // single fetch, ack two cycles after request
    inst_ce_i = 1'b1;
    inst_addr_i = 32'h0;
    #1;
    chk("f1_stall_idle", 32'(stall_o), 32'(STALL_FETCH));
    step();
    chk("f1_req", 32'(bus_if.req), 32'd1);
    chk("f1_sel", 32'(bus_if.sel), 32'hF);
    chk("f1_we", 32'(bus_if.we), 32'd0);
    chk("f1_addr", bus_if.addr, 32'h0);
    step();
    chk("f1_stall_wait", 32'(stall_o), 32'(STALL_FETCH));
    step();
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'h3C010101;
    #1;
    chk("f1_stall_ack", 32'(stall_o), 32'(STALL_FETCH));
    step();
    bus_if.ack = 1'b0;
    #1;
    chk("f1_req_drop", 32'(bus_if.req), 32'd0);
    chk("f1_stall_hit", 32'(stall_o), 32'(STALL_NONE));
    chk("f1_inst_data", inst_data_o, 32'h3C010101);
    step();
    inst_ce_i = 1'b0;
    #1;
    chk("f1_inst_data_ce0", inst_data_o, 32'h0);
    chk("f1_no_refetch", 32'(bus_if.req), 32'd0);
    // store
    data_req(1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);
    #1;
    chk("st_stall_idle", 32'(stall_o), 32'(STALL_DATA));
    step();
    chk("st_req", 32'(bus_if.req), 32'd1);
    chk("st_we", 32'(bus_if.we), 32'd1);
    chk("st_sel", 32'(bus_if.sel), 32'h3);
    chk("st_addr", bus_if.addr, 32'h100);
    chk("st_wdata", bus_if.wdata, 32'hDEADBEEF);
    step();
    chk("st_stall_wait", 32'(stall_o), 32'(STALL_DATA));
    bus_if.ack = 1'b1;
    #1;
    chk("st_stall_ack", 32'(stall_o), 32'(STALL_NONE));
    step();
    bus_if.ack = 1'b0;
    data_ce_i = 1'b0;
    #1;
    chk("st_req_drop", 32'(bus_if.req), 32'd0);
    // collision: load and fetch together, data goes first
    data_req(1'b0, 4'hF, 32'h200, 32'h0);
    inst_ce_i = 1'b1;
    inst_addr_i = 32'h8;
    #1;
    chk("col_stall", 32'(stall_o), 32'(STALL_DATA));
    step();
    chk("col_addr_data", bus_if.addr, 32'h200);
    chk("col_we", 32'(bus_if.we), 32'd0);
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'hCAFEF00D;
    #1;
    chk("col_rdata_bypass", data_rdata_o, 32'hCAFEF00D);
    chk("col_stall_fetch", 32'(stall_o), 32'(STALL_FETCH));
    step();
    bus_if.ack = 1'b0;
    data_ce_i = 1'b0;
    #1;
    chk("col_idle_gap", 32'(bus_if.req), 32'd0);
    chk("col_rdata_held", data_rdata_o, 32'hCAFEF00D);
    step();
    chk("col_fetch_req", 32'(bus_if.req), 32'd1);
    chk("col_addr_fetch", bus_if.addr, 32'h8);
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'h11112222;
    step();
    bus_if.ack = 1'b0;
    #1;
    chk("col_inst_data", inst_data_o, 32'h11112222);
    chk("col_stall_none", 32'(stall_o), 32'(STALL_NONE));
    step();
    // fetch in flight when a load arrives
    inst_addr_i = 32'hC;
    step();
    chk("fd_fetch_req", bus_if.addr, 32'hC);
    data_req(1'b0, 4'hF, 32'h300, 32'h0);
    #1;
    chk("fd_stall_data", 32'(stall_o), 32'(STALL_DATA));
    step();
    chk("fd_fetch_kept", bus_if.addr, 32'hC);
    chk("fd_fetch_req_hi", 32'(bus_if.req), 32'd1);
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'hAAAA5555;
    step();
    bus_if.ack = 1'b0;
    #1;
    chk("fd_gap", 32'(bus_if.req), 32'd0);
    chk("fd_buf_data", inst_data_o, 32'hAAAA5555);
    chk("fd_stall_gap", 32'(stall_o), 32'(STALL_DATA));
    step();
    chk("fd_data_addr", bus_if.addr, 32'h300);
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'h0BADF00D;
    #1;
    chk("fd_stall_release", 32'(stall_o), 32'(STALL_NONE));
    step();
    bus_if.ack = 1'b0;
    data_ce_i = 1'b0;
    inst_ce_i = 1'b0;
    #1;
    chk("fd_req_drop", 32'(bus_if.req), 32'd0);
    chk("fd_rdata_held", data_rdata_o, 32'h0BADF00D);
    step();
    chk("fd_no_new_req", 32'(bus_if.req), 32'd0);
    // timeout on a load that is never acked
    data_req(1'b0, 4'hF, 32'h400, 32'h0);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("to_req_hold", 32'(bus_if.req), 32'd1);
      chk("to_stall_hold", 32'(stall_o), 32'(STALL_DATA));
      step();
    end
    chk("to_req_last", 32'(bus_if.req), 32'd1);
    chk("to_stall_expire", 32'(stall_o), 32'(STALL_NONE));
    chk("to_rdata_zero", data_rdata_o, 32'h0);
    step();
    data_ce_i = 1'b0;
    #1;
    chk("to_req_drop", 32'(bus_if.req), 32'd0);
    chk("to_err", 32'(bus_if.err), 32'd1);
    chk("to_rdata_held", data_rdata_o, 32'h0);
    step();
    step();
    chk("to_err_sticky", 32'(bus_if.err), 32'd1);
    // reset during a fetch, late ack afterwards
    inst_ce_i = 1'b1;
    inst_addr_i = 32'h20;
    step();
    chk("mr_fetch_req", 32'(bus_if.req), 32'd1);
    chk("mr_err_before", 32'(bus_if.err), 32'd1);
    rst = 1'b1;
    inst_ce_i = 1'b0;
    step();
    rst = 1'b0;
    chk("mr_req", 32'(bus_if.req), 32'd0);
    chk("mr_err", 32'(bus_if.err), 32'd0);
    chk("mr_stall", 32'(stall_o), 32'(STALL_NONE));
    chk("mr_inst_data", inst_data_o, 32'h0);
    chk("mr_data_rdata", data_rdata_o, 32'h0);
    bus_if.ack = 1'b1;
    bus_if.rdata = 32'h12345678;
    step();
    bus_if.ack = 1'b0;
    chk("mr_late_ack_req", 32'(bus_if.req), 32'd0);
    chk("mr_late_ack_err", 32'(bus_if.err), 32'd0);
    inst_ce_i = 1'b1;
    #1;
    chk("mr_buf_invalid_stall", 32'(stall_o), 32'(STALL_FETCH));
    chk("mr_buf_invalid_data", inst_data_o, 32'h0);
    step();
    chk("mr_refetch_req", 32'(bus_if.req), 32'd1);
    chk("mr_refetch_addr", bus_if.addr, 32'h20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
